tile_sequencer: RTL and testbench
=================================

Name: tile_sequencer

Overview:
Game controller for the 7-row tile shift register. It generates the tempo-paced shift pulse and supplies the random lane value for the top row. It judges player key presses against the bottom row (line_6), keeps the score, speeds the tempo up, and detects game over. It sits between the key debouncers and the shift register, and drives the score/status display.

Parameters:
BEAT_INIT, 25000000, clocks per beat at game start
BEAT_MIN, 6250000, fastest allowed beat period (clocks)
BEAT_STEP, 1000000, period decrement applied at each speed-up
SPEEDUP_EVERY, 8, number of hits between speed-ups
CNT_W, 26, width of the beat counter and period registers
LFSR_SEED, 8'hA5, LFSR reset value; must be non-zero

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin or restart a game
key  in  4  one-cycle press pulses, one bit per lane, debounced upstream
bottom_lane  in  2  lane of the bottom row (line_6 of the shift register)
shift  out  1  one-cycle pulse that advances the shift register
new_lane  out  2  lane value loaded into the top row; valid whenever shift=1
score  out  16  count of correct hits
hit  out  1  one-cycle pulse on each correct hit
playing  out  1  high in PLAY state
game_over  out  1  high in OVER state

Behaviour:
- Clock and reset: one clock, clk. resetn is asynchronous and active-low. All state and outputs are registered.
- Reset values: state=IDLE, shift=0, hit=0, playing=0, game_over=0, score=0, beat_cnt=0, period=BEAT_INIT, fill_cnt=0, bottom_hit=0, lfsr=LFSR_SEED, new_lane=LFSR_SEED[1:0].
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Advances every clock in every state. new_lane is registered from lfsr[1:0] every clock.
- Beat: beat_cnt counts 0..period-1 in FILL and PLAY and is held at 0 otherwise. "Expiry" is the cycle with beat_cnt==period-1; beat_cnt wraps to 0 on that cycle.
- IDLE: wait for start. On start: score=0, period=BEAT_INIT, beat_cnt=0, fill_cnt=0, go to FILL.
- FILL: on each expiry, shift=1 and fill_cnt++. After the 7th shift, go to PLAY with bottom_hit=0. key is ignored in FILL.
- PLAY, key evaluation (only when key!=0):
  - key not one-hot -> go to OVER.
  - one-hot, index==bottom_lane, bottom_hit=0 -> hit=1, score++ (saturates at 16'hFFFF), bottom_hit=1.
  - one-hot, index==bottom_lane, bottom_hit=1 -> ignored.
  - one-hot, index!=bottom_lane -> go to OVER.
- PLAY, on expiry:
  - bottom_hit=1 -> shift=1, bottom_hit=0.
  - bottom_hit=0 -> go to OVER; no shift.
- Same cycle as expiry:
  - Correct key with bottom_hit=0 -> counts as a hit; shift=1 that cycle; bottom_hit ends 0.
  - Wrong key -> OVER takes priority; no shift.
- Speed-up: when a hit makes score a multiple of SPEEDUP_EVERY, period = max(period-BEAT_STEP, BEAT_MIN). Compute in CNT_W+1 bits; no underflow. The new period takes effect from the current count; if beat_cnt >= new period-1, expiry occurs next cycle.
- OVER: game_over=1. score, shift=0 and hit=0 are held. start restarts exactly as from IDLE.
- Latency: key sampled at edge N; hit, score, or game_over changes are visible after edge N.
- start is ignored in FILL and PLAY.
- playing=1 only in PLAY; game_over=1 only in OVER.
- resetn asserted mid-game forces the reset values immediately, independent of clk.

Test Plan:
Bench parameters for all scenarios: BEAT_INIT=10, BEAT_MIN=4, BEAT_STEP=2, SPEEDUP_EVERY=2.
- Reset, then pulse start -> 7 shift pulses exactly 10 cycles apart; playing=1 after the 7th; key pulses during FILL give no hit and no game_over.
- In PLAY, press the key matching bottom_lane once per beat -> hit pulse each time; score 1,2,3...; period 8 after 2 hits, 6 after 4, 4 after 6, and stays 4 thereafter.
- Press a wrong lane (bottom_lane=2, key=4'b0001) -> game_over=1 the next cycle; no further shift; score held. Pressing key=4'b0101 also gives game_over.
- No key during a full beat -> game_over asserts on expiry with shift=0. Double press of the correct lane in one beat -> score increments once only.
- Correct key on the exact expiry cycle -> score++ and shift in the same cycle; the next beat with no press -> game_over.
- Drive resetn low mid-PLAY (score=5) -> all outputs reach reset values without a clock edge. From OVER, pulse start -> score=0 and FILL sequence restarts.

Source files
------------

// File: rtl/tile_sequencer.sv
// Game controller for the 7-row tile shift register: beat timing, lane
// generation, key judging against the bottom row, scoring and tempo.
//
// state | meaning
// IDLE  | after reset, waiting for start
// FILL  | shifting 7 rows in at the initial tempo, keys ignored
// PLAY  | judging keys against the bottom row each beat
// OVER  | game lost, score held until the next start
module tile_sequencer #(
  parameter int unsigned BEAT_INIT     = 25000000,
  parameter int unsigned BEAT_MIN      = 6250000,
  parameter int unsigned BEAT_STEP     = 1000000,
  parameter int unsigned SPEEDUP_EVERY = 8,
  parameter int unsigned CNT_W         = 26,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [3:0]  key,
  input  logic [1:0]  bottom_lane,
  output logic        shift,
  output logic [1:0]  new_lane,
  output logic [15:0] score,
  output logic        hit,
  output logic        playing,
  output logic        game_over
);

  typedef enum logic [1:0] {IDLE, FILL, PLAY, OVER} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic [CNT_W-1:0] period, period_nxt;
  logic [2:0]       fill_cnt, fill_cnt_nxt;
  logic             bottom_hit, bottom_hit_nxt;
  logic [15:0]      score_nxt;
  logic             shift_nxt, hit_nxt;
  logic [7:0]       lfsr;

  logic             expiry;
  logic             key_match, key_bad, key_good;
  logic [15:0]      score_inc;
  logic             speedup;
  logic [CNT_W:0]   period_dec;
  logic [CNT_W-1:0] period_stepped;

  // >= rather than == so a shortened period that the count already passed
  // still expires on the next cycle.
  assign expiry = (beat_cnt >= (period - CNT_W'(1)));

  // A matching key is one-hot by construction, so anything else non-zero is bad.
  assign key_match = (key == (4'b0001 << bottom_lane));
  assign key_bad   = (|key) && !key_match;
  assign key_good  = key_match && !bottom_hit;

  assign score_inc = (score == 16'hFFFF) ? score : score + 16'd1;
  assign speedup   = (score != 16'hFFFF) &&
                     ((score_inc % 16'(SPEEDUP_EVERY)) == 16'd0);

  assign period_dec     = {1'b0, period} - (CNT_W+1)'(BEAT_STEP);
  assign period_stepped = (period_dec[CNT_W] || (period_dec < (CNT_W+1)'(BEAT_MIN)))
                          ? CNT_W'(BEAT_MIN) : period_dec[CNT_W-1:0];

  always_comb begin
    state_nxt      = state;
    beat_cnt_nxt   = beat_cnt;
    period_nxt     = period;
    fill_cnt_nxt   = fill_cnt;
    bottom_hit_nxt = bottom_hit;
    score_nxt      = score;
    shift_nxt      = 1'b0;
    hit_nxt        = 1'b0;
    case (state)
      IDLE, OVER: begin
        beat_cnt_nxt = '0;
        if (start) begin
          state_nxt    = FILL;
          score_nxt    = 16'd0;
          period_nxt   = CNT_W'(BEAT_INIT);
          fill_cnt_nxt = 3'd0;
        end
      end
      FILL: begin
        if (expiry) begin
          beat_cnt_nxt = '0;
          shift_nxt    = 1'b1;
          fill_cnt_nxt = fill_cnt + 3'd1;
          if (fill_cnt == 3'd6) begin
            state_nxt      = PLAY;
            bottom_hit_nxt = 1'b0;
          end
        end else begin
          beat_cnt_nxt = beat_cnt + CNT_W'(1);
        end
      end
      PLAY: begin
        beat_cnt_nxt = expiry ? '0 : beat_cnt + CNT_W'(1);
        if (key_bad) begin
          state_nxt    = OVER;
          beat_cnt_nxt = '0;
        end else begin
          if (key_good) begin
            hit_nxt   = 1'b1;
            score_nxt = score_inc;
            if (speedup) period_nxt = period_stepped;
          end
          // A hit landing on the expiry cycle itself still earns the shift.
          if (expiry) begin
            if (bottom_hit || key_good) begin
              shift_nxt      = 1'b1;
              bottom_hit_nxt = 1'b0;
            end else begin
              state_nxt = OVER;
            end
          end else if (key_good) begin
            bottom_hit_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      period     <= CNT_W'(BEAT_INIT);
      fill_cnt   <= 3'd0;
      bottom_hit <= 1'b0;
      score      <= 16'd0;
      shift      <= 1'b0;
      hit        <= 1'b0;
      playing    <= 1'b0;
      game_over  <= 1'b0;
      lfsr       <= LFSR_SEED;
      new_lane   <= LFSR_SEED[1:0];
    end else begin
      state      <= state_nxt;
      beat_cnt   <= beat_cnt_nxt;
      period     <= period_nxt;
      fill_cnt   <= fill_cnt_nxt;
      bottom_hit <= bottom_hit_nxt;
      score      <= score_nxt;
      shift      <= shift_nxt;
      hit        <= hit_nxt;
      playing    <= (state_nxt == PLAY);
      game_over  <= (state_nxt == OVER);
      lfsr       <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      new_lane   <= lfsr[1:0];
    end
  end

endmodule

// File: tb/tb_tile_sequencer.sv
// Self-checking bench for tile_sequencer: directed game scenarios, a key
// judging table and randomized play against a behavioural reference model.
module tb_tile_sequencer;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  key = 4'd0;
  logic [1:0]  bl = 2'd0;
  logic        shift;
  logic [1:0]  new_lane;
  logic [15:0] score;
  logic        hit, playing, game_over;

  tile_sequencer #(
    .BEAT_INIT(10), .BEAT_MIN(4), .BEAT_STEP(2), .SPEEDUP_EVERY(2)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .key(key), .bottom_lane(bl),
    .shift(shift), .new_lane(new_lane), .score(score), .hit(hit),
    .playing(playing), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  // Reference model: game mode, cycles elapsed in the current beat, tempo.
  localparam int M_IDLE = 0, M_FILL = 1, M_PLAY = 2, M_OVER = 3;
  int       m_mode, m_elapsed, m_period, m_fills, m_score;
  bit       m_got, m_shift, m_hit;
  bit [7:0] m_lfsr;
  bit [1:0] m_lane;

  // Emulated 7-row shift register feeding bottom_lane.
  logic [1:0] rows [7];
  bit         auto_bl = 1'b1;

  typedef struct {
    logic [3:0] k;
    logic [1:0] lane;
    logic       exp_hit;
    logic       exp_over;
  } vec_t;
  vec_t vt [6];

  int exp_iv [8] = '{10, 8, 8, 6, 6, 4, 4, 4};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_elapsed = 0; m_period = 10; m_fills = 0; m_score = 0;
    m_got = 0; m_shift = 0; m_hit = 0; m_lfsr = 8'hA5; m_lane = 2'b01;
    for (int i = 0; i < 7; i++) rows[i] = 2'd0;
    if (auto_bl) bl = 2'd0;
  endtask

  task automatic model_step(input bit st, input bit [3:0] k, input bit [1:0] lane);
    bit expire, bad, good;
    expire = (m_elapsed + 1 >= m_period);
    m_lane = m_lfsr[1:0];
    m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    m_shift = 0;
    m_hit = 0;
    case (m_mode)
      M_IDLE, M_OVER: if (st) begin
        m_mode = M_FILL; m_score = 0; m_period = 10; m_elapsed = 0; m_fills = 0;
      end
      M_FILL: begin
        if (expire) begin
          m_elapsed = 0; m_shift = 1; m_fills++;
          if (m_fills == 7) begin m_mode = M_PLAY; m_got = 0; end
        end else m_elapsed++;
      end
      M_PLAY: begin
        bad  = (k != 0) && (k != (4'd1 << lane));
        good = !bad && (k != 0) && !m_got;
        if (bad) begin
          m_mode = M_OVER; m_elapsed = 0;
        end else begin
          if (good) begin
            m_hit = 1; m_got = 1;
            if (m_score < 65535) begin
              m_score++;
              if (m_score % 2 == 0) m_period = (m_period - 2 < 4) ? 4 : m_period - 2;
            end
          end
          if (expire) begin
            m_elapsed = 0;
            if (m_got) begin m_shift = 1; m_got = 0; end
            else m_mode = M_OVER;
          end else m_elapsed++;
        end
      end
      default: ;
    endcase
  endtask

  task automatic tick();
    bit       sh_b;
    bit [1:0] ln_b;
    sh_b = m_shift;
    ln_b = m_lane;
    model_step(start, key, bl);
    @(posedge clk);
    #1;
    cyc++;
    if (sh_b) begin
      for (int i = 6; i > 0; i--) rows[i] = rows[i-1];
      rows[0] = ln_b;
    end
    if (auto_bl) bl = rows[6];
    chk("outputs", {10'd0, shift, new_lane, score, hit, playing, game_over},
        {10'd0, m_shift, m_lane, 16'(m_score), m_hit, m_mode == M_PLAY, m_mode == M_OVER});
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_over();
    int n = 0;
    while (!game_over && n < 100) begin tick(); n++; end
    chk("wait_over", game_over, 1);
  endtask

  task automatic wait_play();
    int n = 0;
    while (!playing && n < 200) begin tick(); n++; end
    chk("wait_play", playing, 1);
  endtask

  // Start a game and check the fill tempo; keys pressed meanwhile must be ignored.
  task automatic fill_check();
    int last = 0, n = 0, t = 0;
    bit pressed;
    pulse_start();
    chk("restart_score", score, 0);
    while (n < 7 && t < 200) begin
      pressed = (t % 3 == 1);
      key = pressed ? 4'($urandom_range(1, 15)) : 4'd0;
      tick(); t++; key = 4'd0;
      if (pressed) chk("fill_key_ignored", {hit, game_over}, 0);
      if (shift) begin
        n++;
        chk("fill_interval", t - last, 10);
        last = t;
      end
    end
    chk("fill_shifts", n, 7);
    chk("fill_playing", playing, 1);
  endtask

  // Press the correct lane early in each beat; the beat length tracks the tempo.
  task automatic play_hits(input int nb);
    for (int b = 0; b < nb; b++) begin
      int since = 0;
      do begin
        key = (since == 2) ? 4'(4'd1 << bl) : 4'd0;
        tick(); key = 4'd0; since++;
        if (since == 3) chk("hit_pulse", hit, 1);
      end while (!shift && since < 40);
      chk("beat_interval", since, exp_iv[b]);
      chk("play_score", score, b + 1);
    end
  endtask

  initial begin
    vt[0] = '{4'b0001, 2'd2, 1'b0, 1'b1};
    vt[1] = '{4'b0101, 2'd2, 1'b0, 1'b1};
    vt[2] = '{4'b0100, 2'd2, 1'b1, 1'b0};
    vt[3] = '{4'b1000, 2'd3, 1'b1, 1'b0};
    vt[4] = '{4'b1111, 2'd0, 1'b0, 1'b1};
    vt[5] = '{4'b0010, 2'd0, 1'b0, 1'b1};

    model_reset();
    #1 resetn = 1'b0;
    #1;
    chk("reset_outputs", {10'd0, shift, new_lane, score, hit, playing, game_over},
        {10'd0, 1'b0, 2'b01, 16'd0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    resetn = 1'b1;

    tick();
    tick();
    fill_check();
    play_hits(8);

    foreach (vt[i]) begin
      wait_over();
      pulse_start();
      wait_play();
      auto_bl = 1'b0;
      bl = vt[i].lane;
      tick();
      key = vt[i].k;
      tick();
      key = 4'd0;
      chk("vec_hit", hit, vt[i].exp_hit);
      chk("vec_over", game_over, vt[i].exp_over);
      chk("vec_score", score, vt[i].exp_hit ? 1 : 0);
      tick();
      chk("vec_no_shift", shift && vt[i].exp_over, 0);
      auto_bl = 1'b1;
      bl = rows[6];
    end

    // Double press in one beat, then a hit on the exact expiry cycle, then a miss.
    begin
      int since = 0, n = 0;
      wait_over();
      pulse_start();
      wait_play();
      do begin
        key = (since == 2 || since == 5) ? 4'(4'd1 << bl) : 4'd0;
        tick(); key = 4'd0; since++;
        if (since == 6) chk("double_no_hit", hit, 0);
      end while (!shift && since < 40);
      chk("double_score", score, 1);
      while (m_elapsed != m_period - 1 && n < 50) begin tick(); n++; end
      key = 4'(4'd1 << bl);
      tick();
      key = 4'd0;
      chk("expiry_hit", hit, 1);
      chk("expiry_shift", shift, 1);
      chk("expiry_score", score, 2);
      n = 0;
      while (!game_over && n < 50) begin tick(); n++; end
      chk("miss_latency", n, 8);
      chk("miss_no_shift", shift, 0);
      chk("miss_score_held", score, 2);
    end

    // Asynchronous reset in the middle of a game.
    wait_over();
    pulse_start();
    wait_play();
    play_hits(5);
    chk("pre_reset_score", score, 5);
    #3 resetn = 1'b0;
    #1;
    chk("async_reset", {10'd0, shift, new_lane, score, hit, playing, game_over},
        {10'd0, 1'b0, 2'b01, 16'd0, 1'b0, 1'b0, 1'b0});
    model_reset();
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    fill_check();

    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      start = ($urandom_range(0, 19) == 0);
      if (r < 25)      key = 4'(4'd1 << bl);
      else if (r < 27) key = 4'($urandom_range(1, 15));
      else             key = 4'd0;
      tick();
      start = 1'b0;
      key = 4'd0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
